mprj_logic_seq: RTL



---
 rtl/mprj_logic_pkg.sv | 31 +++
 rtl/mprj_logic_step_timer.sv | 35 +++
 rtl/mprj_logic_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mprj_logic_pkg.sv
// rtl/mprj_logic_pkg.sv - shared state type and slice helpers for the sequenced enable vector
package mprj_logic_pkg;

   typedef enum logic [1:0] {
      OFF       = 2'd0,
      RAMP_UP   = 2'd1,
      ON        = 2'd2,
      RAMP_DOWN = 2'd3
   } seq_state_e;

   function automatic int slice_size(input int width, input int groups);
      return (width + groups - 1) / groups;
   endfunction

   function automatic int slice_lo(input int g, input int width, input int groups);
      return g * slice_size(width, groups);
   endfunction

   // The last group is clipped to the vector width and may be short.
   function automatic int slice_hi(input int g, input int width, input int groups);
      int top;
      top = (g + 1) * slice_size(width, groups);
      if (top > width) top = width;
      return top - 1;
   endfunction

   function automatic logic group_on(input int g, input int lvl);
      return lvl > g;
   endfunction

endpackage

// File: rtl/mprj_logic_step_timer.sv
// rtl/mprj_logic_step_timer.sv - inter-group delay down-counter, reloaded on every step
module mprj_logic_step_timer #(
   parameter int DLY_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             reload,
   input  logic [DLY_W-1:0] dly,
   output logic             tick
);

   logic [DLY_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (reload)
         cnt_d = dly;
      else if (cnt_q != '0)
         cnt_d = cnt_q - DLY_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Loading dly and counting down to zero spaces steps dly+1 cycles apart.
   assign tick = (cnt_q == '0);

endmodule

// File: rtl/mprj_logic_seq.sv
// rtl/mprj_logic_seq.sv - sequenced user-project enable vector, raised and lowered a group at a time
module mprj_logic_seq
   import mprj_logic_pkg::*;
#(
   parameter int WIDTH  = 463,
   parameter int GROUPS = 4,
   parameter int DLY_W  = 8
) (
`ifdef USE_POWER_PINS
   inout  wire              vccd1,
   inout  wire              vssd1,
`endif
   input  logic             wb_clk_i,
   input  logic             wb_rstn_i,
   input  logic             en,
   input  logic             force_lo,
   input  logic [DLY_W-1:0] dly,
   output logic [WIDTH-1:0] HI,
   output logic             done,
   output logic             busy
);

   localparam int SLICE = slice_size(WIDTH, GROUPS);
   localparam int LVL_W = $clog2(GROUPS + 1);
   localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(GROUPS - 1);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

   if (GROUPS < 1 || GROUPS > WIDTH || (GROUPS * SLICE - WIDTH) >= SLICE) begin : g_bad_cfg
      $error("mprj_logic_seq: GROUPS=%0d leaves an empty slice for WIDTH=%0d", GROUPS, WIDTH);
   end

   seq_state_e       state_q, state_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             reload;
   logic             tick;

   mprj_logic_step_timer #(
      .DLY_W (DLY_W)
   ) u_timer (
      .clk    (wb_clk_i),
      .rstn   (wb_rstn_i),
      .clr    (force_lo),
      .reload (reload),
      .dly    (dly),
      .tick   (tick)
   );

   // A direction change or a start from rest steps at once; only continued ramps wait for tick.
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      reload  = 1'b0;
      case (state_q)
         OFF: begin
            if (en) begin
               lvl_d   = lvl_q + LVL_ONE;
               state_d = (lvl_q == LVL_LAST) ? ON : RAMP_UP;
               reload  = 1'b1;
            end
         end
         RAMP_UP: begin
            if (!en) begin
               lvl_d   = lvl_q - LVL_ONE;
               state_d = (lvl_q == LVL_ONE) ? OFF : RAMP_DOWN;
               reload  = 1'b1;
            end else if (tick) begin
               lvl_d   = lvl_q + LVL_ONE;
               state_d = (lvl_q == LVL_LAST) ? ON : RAMP_UP;
               reload  = 1'b1;
            end
         end
         ON: begin
            if (!en) begin
               lvl_d   = lvl_q - LVL_ONE;
               state_d = (lvl_q == LVL_ONE) ? OFF : RAMP_DOWN;
               reload  = 1'b1;
            end
         end
         RAMP_DOWN: begin
            if (en) begin
               lvl_d   = lvl_q + LVL_ONE;
               state_d = (lvl_q == LVL_LAST) ? ON : RAMP_UP;
               reload  = 1'b1;
            end else if (tick) begin
               lvl_d   = lvl_q - LVL_ONE;
               state_d = (lvl_q == LVL_ONE) ? OFF : RAMP_DOWN;
               reload  = 1'b1;
            end
         end
         default: begin
            state_d = OFF;
            lvl_d   = '0;
         end
      endcase
      if (force_lo) begin
         state_d = OFF;
         lvl_d   = '0;
         reload  = 1'b0;
      end
   end

   for (genvar g = 0; g < GROUPS; g++) begin : g_slice
      localparam int LO = slice_lo(g, WIDTH, GROUPS);
      localparam int HB = slice_hi(g, WIDTH, GROUPS);
      assign hi_d[HB:LO] = {(HB - LO + 1){group_on(g, int'(lvl_d))}};
   end

   always_comb begin
      done_d = (state_d == ON);
      busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         state_q <= OFF;
         lvl_q   <= '0;
         hi_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         hi_q    <= hi_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign HI   = hi_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule
